// File: rtl/timer_input_conditioner.sv
// Input front end for the countdown timer: key sync/debounce,
// switch sync, gated 1 Hz tick and free-running flash square wave.
module timer_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 50000000,
  parameter int FLASH_HALF      = 12500000
) (
  input  logic       CLOCK_50,
  input  logic       reset_btn,
  input  logic [2:0] key_n,
  input  logic [7:0] sw,
  input  logic       tick_en,
  input  logic       tick_clr,
  output logic [2:0] key_press,
  output logic [2:0] key_level,
  output logic [7:0] sw_sync,
  output logic       tick_1hz,
  output logic       flash
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam int FW = $clog2(FLASH_HALF + 1);

  localparam logic [DW-1:0] DB_ONE  = DW'(1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] TK_ONE  = TW'(1);
  localparam logic [TW-1:0] TK_LAST = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FL_ONE  = FW'(1);
  localparam logic [FW-1:0] FL_LAST = FW'(FLASH_HALF - 1);

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  logic [2:0]    key_meta_q;
  logic [2:0]    key_sync_q;
  logic [7:0]    sw_meta_q;
  logic [7:0]    sw_sync_q;

  logic [1:0]    st_q  [3];
  logic [1:0]    st_d  [3];
  logic [DW-1:0] cnt_q [3];
  logic [DW-1:0] cnt_d [3];
  logic [2:0]    press_q;
  logic [2:0]    press_d;
  logic [2:0]    level_q;
  logic [2:0]    level_d;

  logic [TW-1:0] tick_cnt_q;
  logic [TW-1:0] tick_cnt_d;
  logic          tick_q;
  logic          tick_d;

  logic [FW-1:0] fl_cnt_q;
  logic [FW-1:0] fl_cnt_d;
  logic          flash_q;
  logic          flash_d;

  // Key sync flops park at 1 so reset looks like "all released".
  always_ff @(posedge CLOCK_50 or negedge reset_btn) begin
    if (!reset_btn) begin
      key_meta_q <= 3'b111;
      key_sync_q <= 3'b111;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      key_meta_q <= key_n;
      key_sync_q <= key_meta_q;
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  always_comb begin
    press_d = '0;
    level_d = level_q;
    for (int i = 0; i < 3; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      unique case (st_q[i])
        ST_RELEASED: begin
          cnt_d[i] = '0;
          if (!key_sync_q[i]) begin
            st_d[i]  = ST_PRESS_WAIT;
            cnt_d[i] = DB_ONE;
          end
        end
        ST_PRESS_WAIT: begin
          if (key_sync_q[i]) begin
            st_d[i]  = ST_RELEASED;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            st_d[i]    = ST_PRESSED;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
            level_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + DB_ONE;
          end
        end
        ST_PRESSED: begin
          level_d[i] = 1'b1;
          cnt_d[i]   = '0;
          if (key_sync_q[i]) begin
            st_d[i]  = ST_RELEASE_WAIT;
            cnt_d[i] = DB_ONE;
          end
        end
        ST_RELEASE_WAIT: begin
          if (!key_sync_q[i]) begin
            st_d[i]  = ST_PRESSED;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            st_d[i]    = ST_RELEASED;
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + DB_ONE;
          end
        end
        default: begin
          st_d[i]    = ST_RELEASED;
          cnt_d[i]   = '0;
          level_d[i] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_btn) begin
    if (!reset_btn) begin
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= ST_RELEASED;
        cnt_q[i] <= '0;
      end
      press_q <= '0;
      level_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      press_q <= press_d;
      level_q <= level_d;
    end
  end

  // Clear beats enable; a disabled divider freezes its phase.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick_d     = 1'b0;
    if (tick_clr) begin
      tick_cnt_d = '0;
    end else if (tick_en) begin
      if (tick_cnt_q == TK_LAST) begin
        tick_cnt_d = '0;
        tick_d     = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + TK_ONE;
      end
    end
  end

  always_comb begin
    fl_cnt_d = fl_cnt_q + FL_ONE;
    flash_d  = flash_q;
    if (fl_cnt_q == FL_LAST) begin
      fl_cnt_d = '0;
      flash_d  = ~flash_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_btn) begin
    if (!reset_btn) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      fl_cnt_q   <= '0;
      flash_q    <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      fl_cnt_q   <= fl_cnt_d;
      flash_q    <= flash_d;
    end
  end

  assign key_press = press_q;
  assign key_level = level_q;
  assign sw_sync   = sw_sync_q;
  assign tick_1hz  = tick_q;
  assign flash     = flash_q;

endmodule
